// File: rtl/arf_mon_pkg.sv
// Shared types and saturating arithmetic for the ARF error monitor.
// Saturating adds work at a wide internal width and clamp to a runtime accumulator width.
package arf_mon_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   // Internal add width; must exceed both the accumulator and the squared-error widths.
   localparam int unsigned SAT_W = 128;

   function automatic int unsigned err_w(input int unsigned data_w);
      return data_w + 1;
   endfunction

   function automatic int unsigned sq_w(input int unsigned data_w);
      return 2 * data_w + 2;
   endfunction

   function automatic logic [SAT_W-1:0] sat_add_u(input logic [SAT_W-1:0] acc,
                                                  input logic [SAT_W-1:0] opnd,
                                                  input int unsigned w,
                                                  output logic sat);
      logic [SAT_W:0] sum;
      logic [SAT_W:0] lim;
      sum = {1'b0, acc} + {1'b0, opnd};
      lim = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
      sat = (sum > lim);
      return sat ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
   endfunction

   function automatic logic [SAT_W-1:0] sat_add_s(input logic [SAT_W-1:0] acc,
                                                  input logic [SAT_W-1:0] opnd,
                                                  input int unsigned w,
                                                  output logic sat);
      logic signed [SAT_W:0] sum;
      logic signed [SAT_W:0] hi;
      logic signed [SAT_W:0] lo;
      sum = $signed({acc[SAT_W-1], acc}) + $signed({opnd[SAT_W-1], opnd});
      hi  = $signed(((SAT_W+1)'(1) << (w - 1)) - (SAT_W+1)'(1));
      lo  = $signed(-((SAT_W+1)'(1) << (w - 1)));
      sat = (sum > hi) || (sum < lo);
      if (sum > hi) return hi[SAT_W-1:0];
      if (sum < lo) return lo[SAT_W-1:0];
      return sum[SAT_W-1:0];
   endfunction

endpackage

// File: rtl/arf_err_lane.sv
// One channel of the error monitor: 3-stage error/square pipeline feeding
// saturating accumulators, running max of |err| and a sticky overflow flag.
module arf_err_lane
   import arf_mon_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ACC_W  = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     beat_valid,
   input  logic signed [DATA_W-1:0] approx,
   input  logic signed [DATA_W-1:0] exact,
   output logic                     s1_valid,
   output logic signed [ACC_W-1:0]  sum_err,
   output logic [ACC_W-1:0]         sum_sq_err,
   output logic [ACC_W-1:0]         sum_abs_exact,
   output logic [DATA_W:0]          max_abs_err,
   output logic                     ovf
);

   localparam int unsigned ERR_W = err_w(DATA_W);
   localparam int unsigned SQ_W  = sq_w(DATA_W);

   logic                    s1_valid_q, s2_valid_q;
   logic signed [ERR_W-1:0] s1_err_q, s2_err_q;
   logic [ERR_W-1:0]        s1_absx_q, s2_absx_q, s2_abse_q;
   logic [SQ_W-1:0]         s2_sq_q;

   logic signed [ERR_W-1:0] approx_x, exact_x, err_d;
   logic [ERR_W-1:0]        absx_d, abse_d;
   logic signed [SQ_W-1:0]  err_sx;
   logic [SQ_W-1:0]         sq_d;

   always_comb begin
      approx_x = ERR_W'(approx);
      exact_x  = ERR_W'(exact);
      err_d    = approx_x - exact_x;
      absx_d   = exact_x[ERR_W-1] ? $unsigned(-exact_x) : $unsigned(exact_x);
      err_sx   = SQ_W'(s1_err_q);
      sq_d     = $unsigned(err_sx * err_sx);
      abse_d   = s1_err_q[ERR_W-1] ? $unsigned(-s1_err_q) : $unsigned(s1_err_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_err_q   <= '0;
         s1_absx_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_err_q   <= '0;
         s2_sq_q    <= '0;
         s2_abse_q  <= '0;
         s2_absx_q  <= '0;
      end else begin
         s1_valid_q <= beat_valid & ~clear;
         s1_err_q   <= err_d;
         s1_absx_q  <= absx_d;
         s2_valid_q <= s1_valid_q & ~clear;
         s2_err_q   <= s1_err_q;
         s2_sq_q    <= sq_d;
         s2_abse_q  <= abse_d;
         s2_absx_q  <= s1_absx_q;
      end
   end

   logic signed [ACC_W-1:0] sum_err_q, sum_err_d;
   logic [ACC_W-1:0]        sum_sq_q, sum_sq_d, sum_abs_q, sum_abs_d;
   logic [ERR_W-1:0]        max_q, max_d;
   logic                    ovf_q, ovf_d;
   logic                    sat_e, sat_q, sat_a;

   always_comb begin
      sat_e     = 1'b0;
      sat_q     = 1'b0;
      sat_a     = 1'b0;
      sum_err_d = ACC_W'(sat_add_s(SAT_W'(sum_err_q), SAT_W'(s2_err_q), ACC_W, sat_e));
      sum_sq_d  = ACC_W'(sat_add_u(SAT_W'(sum_sq_q), SAT_W'(s2_sq_q), ACC_W, sat_q));
      sum_abs_d = ACC_W'(sat_add_u(SAT_W'(sum_abs_q), SAT_W'(s2_absx_q), ACC_W, sat_a));
      max_d     = (s2_abse_q > max_q) ? s2_abse_q : max_q;
      ovf_d     = ovf_q | sat_e | sat_q | sat_a;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_err_q <= '0;
         sum_sq_q  <= '0;
         sum_abs_q <= '0;
         max_q     <= '0;
         ovf_q     <= 1'b0;
      end else if (clear) begin
         sum_err_q <= '0;
         sum_sq_q  <= '0;
         sum_abs_q <= '0;
         max_q     <= '0;
         ovf_q     <= 1'b0;
      end else if (s2_valid_q) begin
         sum_err_q <= sum_err_d;
         sum_sq_q  <= sum_sq_d;
         sum_abs_q <= sum_abs_d;
         max_q     <= max_d;
         ovf_q     <= ovf_d;
      end
   end

   // Stage 2 always lands next edge, so only stage 1 can still hold pending work.
   assign s1_valid      = s1_valid_q;
   assign sum_err       = sum_err_q;
   assign sum_sq_err    = sum_sq_q;
   assign sum_abs_exact = sum_abs_q;
   assign max_abs_err   = max_q;
   assign ovf           = ovf_q;

endmodule

// File: rtl/arf_error_monitor.sv
// Streaming approximate-vs-exact error statistics over a programmable beat window.
// Holds the window FSM, beat counter and per-channel readout mux.
module arf_error_monitor
   import arf_mon_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned ACC_W  = 64,
   parameter int unsigned WIN_W  = 16,
   localparam int unsigned RD_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [WIN_W-1:0]         window_len,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_CH*DATA_W-1:0] approx_data,
   input  logic [NUM_CH*DATA_W-1:0] exact_data,
   input  logic [RD_W-1:0]          rd_ch,
   output logic                     busy,
   output logic                     done,
   output logic [WIN_W-1:0]         count,
   output logic signed [ACC_W-1:0]  sum_err,
   output logic [ACC_W-1:0]         sum_sq_err,
   output logic [ACC_W-1:0]         sum_abs_exact,
   output logic [DATA_W:0]          max_abs_err,
   output logic                     ovf
);

   state_e           state_q, state_d;
   logic [WIN_W-1:0] count_q, len_q;
   logic             clear, beat;
   logic [NUM_CH-1:0] s1_valid;

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      clear    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               clear   = 1'b1;
            end
         end
         StRun: begin
            busy     = 1'b1;
            in_ready = (count_q != len_q);
            if ((count_q == len_q) || (in_valid && (count_q + WIN_W'(1) == len_q))) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            busy = 1'b1;
            if (!(|s1_valid)) state_d = StDone;
         end
         StDone: begin
            done = 1'b1;
            if (start) begin
               state_d = StRun;
               clear   = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign beat = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         count_q <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         if (clear) begin
            count_q <= '0;
            len_q   <= window_len;
         end else if (beat) begin
            count_q <= count_q + WIN_W'(1);
         end
      end
   end

   assign count = count_q;

   logic signed [ACC_W-1:0] lane_sum_err [NUM_CH];
   logic [ACC_W-1:0]        lane_sum_sq  [NUM_CH];
   logic [ACC_W-1:0]        lane_sum_abs [NUM_CH];
   logic [DATA_W:0]         lane_max     [NUM_CH];
   logic                    lane_ovf     [NUM_CH];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      arf_err_lane #(
         .DATA_W (DATA_W),
         .ACC_W  (ACC_W)
      ) u_lane (
         .clk           (clk),
         .rst_n         (rst_n),
         .clear         (clear),
         .beat_valid    (beat),
         .approx        (approx_data[c*DATA_W +: DATA_W]),
         .exact         (exact_data[c*DATA_W +: DATA_W]),
         .s1_valid      (s1_valid[c]),
         .sum_err       (lane_sum_err[c]),
         .sum_sq_err    (lane_sum_sq[c]),
         .sum_abs_exact (lane_sum_abs[c]),
         .max_abs_err   (lane_max[c]),
         .ovf           (lane_ovf[c])
      );
   end

   always_comb begin
      sum_err       = '0;
      sum_sq_err    = '0;
      sum_abs_exact = '0;
      max_abs_err   = '0;
      ovf           = 1'b0;
      if (32'(rd_ch) < NUM_CH) begin
         sum_err       = lane_sum_err[rd_ch];
         sum_sq_err    = lane_sum_sq[rd_ch];
         sum_abs_exact = lane_sum_abs[rd_ch];
         max_abs_err   = lane_max[rd_ch];
         ovf           = lane_ovf[rd_ch];
      end
   end

endmodule

// File: tb/tb_arf_error_monitor.sv
// Randomized bench for arf_error_monitor: a beat-level reference model checked every
// cycle, plus directed windows with hand-computed expectations.
module tb_arf_error_monitor;

   localparam int DW = 32;
   localparam int NC = 2;
   localparam int AW = 40;
   localparam int WW = 16;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic [WW-1:0]        window_len = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [NC*DW-1:0]     approx_data = '0;
   logic [NC*DW-1:0]     exact_data = '0;
   logic [0:0]           rd_ch = '0;
   logic                 busy, done, ovf;
   logic [WW-1:0]        count;
   logic signed [AW-1:0] sum_err;
   logic [AW-1:0]        sum_sq_err, sum_abs_exact;
   logic [DW:0]          max_abs_err;

   always #5 clk = ~clk;

   arf_error_monitor #(
      .DATA_W (DW),
      .NUM_CH (NC),
      .ACC_W  (AW),
      .WIN_W  (WW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .window_len    (window_len),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .approx_data   (approx_data),
      .exact_data    (exact_data),
      .rd_ch         (rd_ch),
      .busy          (busy),
      .done          (done),
      .count         (count),
      .sum_err       (sum_err),
      .sum_sq_err    (sum_sq_err),
      .sum_abs_exact (sum_abs_exact),
      .max_abs_err   (max_abs_err),
      .ovf           (ovf)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic signed [127:0] act,
                        input logic signed [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {MIdle, MRun, MDrain, MDone} mph_t;
   typedef struct {
      int          vis;
      logic [63:0] a;
      logic [63:0] e;
   } beat_t;

   localparam logic signed [127:0] SMAX = (128'sd1 <<< (AW - 1)) - 128'sd1;
   localparam logic signed [127:0] SMIN = -(128'sd1 <<< (AW - 1));
   localparam logic signed [127:0] UMAX = (128'sd1 <<< AW) - 128'sd1;

   mph_t ph = MIdle;
   int   mcnt = 0, mlen = 0, cyc = 0, last = 0;
   beat_t pend[$];
   logic signed [127:0] m_se[NC], m_sq[NC], m_sa[NC], m_mx[NC];
   bit   m_ovf[NC];

   function automatic logic signed [127:0] lane_val(input logic [63:0] bus, input int c);
      logic signed [31:0] v;
      v = bus[c*32 +: 32];
      return 128'(v);
   endfunction

   task automatic m_clear();
      for (int c = 0; c < NC; c++) begin
         m_se[c] = 0; m_sq[c] = 0; m_sa[c] = 0; m_mx[c] = 0; m_ovf[c] = 0;
      end
      pend.delete();
   endtask

   task automatic m_apply(input beat_t b);
      logic signed [127:0] err, ex, aerr, aex;
      for (int c = 0; c < NC; c++) begin
         ex   = lane_val(b.e, c);
         err  = lane_val(b.a, c) - ex;
         aerr = (err < 0) ? -err : err;
         aex  = (ex < 0) ? -ex : ex;
         m_se[c] = m_se[c] + err;
         if (m_se[c] > SMAX) begin m_se[c] = SMAX; m_ovf[c] = 1; end
         if (m_se[c] < SMIN) begin m_se[c] = SMIN; m_ovf[c] = 1; end
         m_sq[c] = m_sq[c] + err * err;
         if (m_sq[c] > UMAX) begin m_sq[c] = UMAX; m_ovf[c] = 1; end
         m_sa[c] = m_sa[c] + aex;
         if (m_sa[c] > UMAX) begin m_sa[c] = UMAX; m_ovf[c] = 1; end
         if (aerr > m_mx[c]) m_mx[c] = aerr;
      end
   endtask

   // Window rules: beats enter while count < len; each is visible two edges after its
   // accept edge; done follows once the last accepted beat has landed.
   initial begin
      m_clear();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            ph = MIdle; mcnt = 0; mlen = 0;
            m_clear();
         end else begin
            cyc++;
            case (ph)
               MIdle, MDone: if (start) begin
                  ph = MRun; mcnt = 0; mlen = int'(window_len); last = cyc;
                  m_clear();
               end
               MRun: begin
                  if (in_valid && mcnt < mlen) begin
                     pend.push_back('{vis: cyc + 2, a: approx_data, e: exact_data});
                     mcnt++;
                     last = cyc;
                  end
                  if (mcnt == mlen) ph = MDrain;
               end
               MDrain: if (cyc >= last + 2) ph = MDone;
               default: ph = MIdle;
            endcase
            while (pend.size() > 0 && pend[0].vis <= cyc) m_apply(pend.pop_front());
         end
      end
   end

   initial begin
      int r;
      logic signed [127:0] se;
      forever begin
         @(negedge clk);
         r  = int'(rd_ch);
         se = sum_err;
         check("in_ready", in_ready, (ph == MRun && mcnt < mlen));
         check("busy", busy, (ph == MRun || ph == MDrain));
         check("done", done, (ph == MDone));
         check("count", count, mcnt);
         check("sum_err", se, m_se[r]);
         check("sum_sq_err", sum_sq_err, m_sq[r]);
         check("sum_abs_exact", sum_abs_exact, m_sa[r]);
         check("max_abs_err", max_abs_err, m_mx[r]);
         check("ovf", ovf, m_ovf[r]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic v, input logic [31:0] a0, input logic [31:0] e0,
                           input logic [31:0] a1, input logic [31:0] e1);
      in_valid    = v;
      approx_data = {a1, a0};
      exact_data  = {e1, e0};
   endtask

   task automatic pulse_start(input int len);
      start      = 1'b1;
      window_len = WW'(len);
      step();
      start      = 1'b0;
   endtask

   task automatic wait_done(input int maxc, input string name);
      int i;
      i = 0;
      while (!done && i < maxc) begin
         step();
         i++;
      end
      check(name, done, 1);
   endtask

   function automatic logic [31:0] small_val();
      return 32'($urandom_range(200)) - 32'd100;
   endfunction

   function automatic logic [31:0] rnd_val();
      if ($urandom_range(1) == 1) return $urandom;
      return 32'($urandom_range(64)) - 32'd32;
   endfunction

   initial begin
      int ta[4];
      int te[4];
      logic signed [127:0] abs_acc, tmp;
      logic [31:0] x0, x1;
      int nv;

      // Reset
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_count", count, 0);
      check("rst_ready", in_ready, 0);
      rst_n = 1'b1;
      step();

      // Directed ch0 window of 4
      ta = '{10, 5, -3, 0};
      te = '{7, 5, 1, 2};
      rd_ch = 1'b0;
      pulse_start(4);
      for (int i = 0; i < 4; i++) begin
         set_beat(1'b1, 32'(ta[i]), 32'(te[i]), small_val(), small_val());
         step();
      end
      in_valid = 1'b0;
      check("t1_done_early", done, 0);
      step();
      check("t1_done_early2", done, 0);
      step();
      check("t1_done_at_3", done, 1);
      check("t1_sum_err", sum_err, -3);
      check("t1_sum_sq", sum_sq_err, 29);
      check("t1_sum_abs", sum_abs_exact, 15);
      check("t1_max", max_abs_err, 4);
      check("t1_count", count, 4);

      // Zero-length window
      pulse_start(0);
      set_beat(1'b1, small_val(), small_val(), small_val(), small_val());
      for (int i = 0; i < 4; i++) begin
         check("t2_no_ready", in_ready, 0);
         step();
      end
      in_valid = 1'b0;
      check("t2_done", done, 1);
      check("t2_count", count, 0);
      check("t2_sum_err", sum_err, 0);
      check("t2_sum_abs", sum_abs_exact, 0);

      // Toggling valid, identical approx/exact
      abs_acc = 0;
      nv = 0;
      pulse_start(8);
      for (int i = 0; i < 16; i++) begin
         x0 = $urandom;
         x1 = $urandom;
         set_beat((i % 2) == 0, x0, x0, x1, x1);
         if ((i % 2) == 0 && nv < 8) begin
            tmp = lane_val({32'd0, x0}, 0);
            abs_acc = abs_acc + ((tmp < 0) ? -tmp : tmp);
            nv++;
         end
         step();
      end
      in_valid = 1'b0;
      wait_done(6, "t3_done");
      check("t3_count", count, 8);
      check("t3_sum_err", sum_err, 0);
      check("t3_sum_sq", sum_sq_err, 0);
      check("t3_max", max_abs_err, 0);
      check("t3_sum_abs", sum_abs_exact, abs_acc);

      // Saturation on ch0 only
      pulse_start(300);
      for (int i = 0; i < 300; i++) begin
         set_beat(1'b1, 32'h8000_0000, 32'd0, 32'($urandom_range(511)), 32'($urandom_range(511)));
         step();
      end
      in_valid = 1'b0;
      wait_done(6, "t4_done");
      rd_ch = 1'b0;
      #1;
      check("t4_sum_err_sat", sum_err, -(128'sd1 <<< 39));
      check("t4_ovf_ch0", ovf, 1);
      rd_ch = 1'b1;
      #1;
      check("t4_ovf_ch1", ovf, 0);
      rd_ch = 1'b0;

      // Reset mid-window
      pulse_start(5);
      for (int i = 0; i < 2; i++) begin
         set_beat(1'b1, 32'd50, 32'd3, 32'd9, 32'd1);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("t5_busy", busy, 0);
      check("t5_count", count, 0);
      check("t5_sum_err", sum_err, 0);
      check("t5_sum_sq", sum_sq_err, 0);
      step();
      rst_n = 1'b1;
      step();
      pulse_start(5);
      for (int i = 0; i < 5; i++) begin
         set_beat(1'b1, 32'd1, 32'd0, small_val(), small_val());
         step();
      end
      in_valid = 1'b0;
      wait_done(6, "t5_done");
      check("t5_new_sum_err", sum_err, 5);
      check("t5_new_sum_sq", sum_sq_err, 5);
      check("t5_new_count", count, 5);

      // Start in DRAIN is ignored, start in DONE restarts
      pulse_start(3);
      for (int i = 0; i < 3; i++) begin
         set_beat(1'b1, 32'd2, 32'd1, small_val(), small_val());
         step();
      end
      in_valid = 1'b0;
      pulse_start(7);
      check("t6_still_busy", busy, 1);
      step();
      check("t6_done", done, 1);
      check("t6_count", count, 3);
      check("t6_sum_err", sum_err, 3);
      pulse_start(2);
      check("t6_rerun_busy", busy, 1);
      check("t6_rerun_count", count, 0);
      check("t6_rerun_clear", sum_err, 0);
      for (int i = 0; i < 2; i++) begin
         set_beat(1'b1, small_val(), small_val(), small_val(), small_val());
         step();
      end
      in_valid = 1'b0;
      wait_done(6, "t6_rerun_done");
      check("t6_rerun_final_count", count, 2);

      // Randomized traffic
      for (int i = 0; i < 900; i++) begin
         start      = ($urandom_range(15) == 0);
         window_len = WW'($urandom_range(12));
         set_beat($urandom_range(3) != 0, rnd_val(), rnd_val(), rnd_val(), rnd_val());
         rd_ch      = 1'($urandom_range(1));
         step();
      end
      start    = 1'b0;
      in_valid = 1'b0;
      repeat (10) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/arf_error_monitor.md
Name: arf_error_monitor

Overview:
- Synthesisable, streaming successor to the simulation-only error-statistics bench for the approximate vs accurate ARF datapaths.
- Takes NUM_CH paired samples (approximate, exact) per beat over a valid/ready stream.
- Accumulates per-channel error statistics over a programmable window: sum of error, sum of squared error, sum of |exact|, max |error|.
- Sits beside the approximate datapath so mean, variance, MSE and SNR are derived by software from the sums, for any channel count and width.

Parameters:
- DATA_W, 32, signed width of each approximate/exact sample.
- NUM_CH, 2, number of output channels compared per beat.
- ACC_W, 64, width of each accumulator (sums saturate at this width).
- WIN_W, 16, width of the window length / sample counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: clear accumulators and begin a window.
- window_len  in  WIN_W  number of beats to accept; sampled on start.
- in_valid  in  1  sample beat valid.
- in_ready  out  1  monitor accepts a beat this cycle.
- approx_data  in  NUM_CH*DATA_W  packed signed approximate outputs; channel 0 in the LSBs.
- exact_data  in  NUM_CH*DATA_W  packed signed accurate outputs, same packing.
- rd_ch  in  clog2(NUM_CH) (min 1)  channel selected for result readout.
- busy  out  1  window in progress (RUN or DRAIN).
- done  out  1  high in DONE; results stable.
- count  out  WIN_W  beats accumulated in the current window.
- sum_err  out  ACC_W  signed Σ(approx−exact) of rd_ch.
- sum_sq_err  out  ACC_W  unsigned Σ(approx−exact)² of rd_ch.
- sum_abs_exact  out  ACC_W  unsigned Σ|exact| of rd_ch.
- max_abs_err  out  DATA_W+1  unsigned max |approx−exact| of rd_ch.
- ovf  out  1  sticky saturation flag of rd_ch.

Behaviour:
- Reset (rst_n low, async): state IDLE. in_ready=0, busy=0, done=0, count=0. All accumulators, max and ovf registers=0. Pipeline valid bits=0. Reset mid-window abandons the window with no partial results kept.
- States:
  - IDLE: start → RUN. Clears all channel accumulators, count and ovf; latches window_len.
  - RUN: in_ready=1. Beat accepted when in_valid&&in_ready; count increments. When count reaches the latched length → DRAIN, with in_ready=0 from the cycle after the last accept.
  - DRAIN: waits until all pipeline valid bits clear (3 cycles max) → DONE.
  - DONE: done=1, outputs hold. start → RUN with a fresh clear.
- window_len=0 on start: RUN accepts no beat; goes straight to DRAIN then DONE with all results 0.
- start while busy: ignored.
- Pipeline, 3 stages per channel:
  - S1 registers err = approx − exact at DATA_W+1 bits signed, exact abs at DATA_W+1 bits.
  - S2 registers err² (2*DATA_W+2 bits unsigned) and |err|.
  - S3 updates the accumulators.
  - A beat accepted in cycle t is visible in the sums at t+3.
  - count reflects accepted beats immediately.
- Width and saturation rules:
  - Operands are sign/zero-extended to ACC_W before adding.
  - sum_err saturates at ±(2^(ACC_W−1)−1 / −2^(ACC_W−1)).
  - sum_sq_err and sum_abs_exact saturate at 2^ACC_W−1.
  - Any saturation sets that channel's ovf until the next start.
  - max_abs_err updates when |err| > current max (strict).
- Readout: combinational mux on rd_ch from the registered accumulators. rd_ch ≥ NUM_CH returns all zeros.
- Back-to-back beats at full rate: no bubbles. in_valid low stalls nothing downstream; the pipeline advances unconditionally with per-stage valid bits.

Decomposition:
- Package arf_mon_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - localparam ERR_W = DATA_W+1 and SQ_W = 2*DATA_W+2;
  - saturating-add functions (signed and unsigned).
- Sub-module arf_err_lane: one per channel via generate. Holds the 3-stage error/square pipeline plus that channel's accumulators, max and ovf. Inputs: clear, beat valid, approx, exact.
- The top holds the FSM, counter and readout mux.

Test Plan:
- Window of 4, NUM_CH=2, ch0 approx/exact = (10,7),(5,5),(−3,1),(0,2) → sum_err=−3, sum_sq_err=29, sum_abs_exact=15, max_abs_err=4, count=4, done 3 cycles after last accept.
- window_len=0 then start → done within 4 cycles, all sums 0, no beat accepted (in_ready never high with in_valid).
- in_valid toggling 1,0,1,0 over an 8-beat window with identical approx/exact → count=8, all error sums 0, sum_abs_exact = Σ|exact|.
- DATA_W=32, ACC_W=40, repeated err = −2^31 for 300 beats → sum_err saturates to −2^39, ovf=1 on ch0, ch1 ovf=0.
- rst_n pulled low mid-RUN after 2 of 5 beats → busy=0, count=0, sums 0. A new start runs a clean window whose results ignore the earlier beats.
- start asserted during DRAIN and again in DONE → first ignored; second clears results and re-enters RUN with count=0.
